register_file_mp: RTL and testbench

//   Parametrised multi-port general-purpose register file for the ID stage.

---
 rtl/register_file_mp.sv | 84 ++++++++
 tb/tb_register_file_mp.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port GPR file feeding the ID/EX operand registers.
// Registered reads with write bypass, per-port hold and an optional zero register.
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_READ-1:0]            rd_en,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
  input  logic                           wr0_en,
  input  logic                           wr0_no_op,
  input  logic [ADDR_WIDTH-1:0]          wr0_addr,
  input  logic [DATA_WIDTH-1:0]          wr0_data,
  input  logic                           wr1_en,
  input  logic [ADDR_WIDTH-1:0]          wr1_addr,
  input  logic [DATA_WIDTH-1:0]          wr1_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]          mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]          mem_d [DEPTH];
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data_q;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data_d;
  logic                           w0;
  logic                           w1;
  logic [ADDR_WIDTH-1:0]          rd_a;

  // Qualify both write ports; r0 swallows writes when hardwired
  always_comb begin
    w0 = wr0_en & ~wr0_no_op;
    w1 = wr1_en;
    if (ZERO_REG && wr0_addr == '0) w0 = 1'b0;
    if (ZERO_REG && wr1_addr == '0) w1 = 1'b0;
  end

  // Next register contents; port 1 wins a same-address collision
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (w0 && wr0_addr == ADDR_WIDTH'(i)) mem_d[i] = wr0_data;
      if (w1 && wr1_addr == ADDR_WIDTH'(i)) mem_d[i] = wr1_data;
    end
  end

  // Next read data per port: hold when disabled, else forwarded value
  always_comb begin
    rd_data_d = rd_data_q;
    rd_a      = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      rd_a = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      if (rd_en[k]) begin
        if (ZERO_REG && rd_a == '0) begin
          rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        end else if (BYPASS && w1 && wr1_addr == rd_a) begin
          rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] = wr1_data;
        end else if (BYPASS && w0 && wr0_addr == rd_a) begin
          rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] = wr0_data;
        end else begin
          rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_a];
        end
      end
    end
  end

  // State update; reset clears every register and read port at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: scoreboard bench for register_file_mp.
// Instance A: 32 regs, bypass on. Instance B: 8 regs, bypass off.
module tb_register_file_mp;

  localparam int DW = 32;
  localparam int AA = 5;
  localparam int AB = 3;
  localparam int NR = 4;

  typedef struct packed {
    logic [15:0]      id;
    logic [NR*DW-1:0] ea;
    logic [NR-1:0]    ma;
    logic [NR*DW-1:0] eb;
    logic [NR-1:0]    mb;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    rd_en;
  logic [NR*AA-1:0] a_rd_addr;
  logic [NR*AB-1:0] b_rd_addr;
  logic [NR*DW-1:0] a_rd_data;
  logic [NR*DW-1:0] b_rd_data;
  logic             wr0_en;
  logic             wr0_no_op;
  logic [AA-1:0]    wr0_addr;
  logic [DW-1:0]    wr0_data;
  logic             wr1_en;
  logic [AA-1:0]    wr1_addr;
  logic [DW-1:0]    wr1_data;

  rec_t             sb[$];
  logic [NR*DW-1:0] exp_a;
  logic [NR-1:0]    msk_a;
  logic [DW-1:0]    mdl [8];
  int               n_chk = 0;
  int               n_fail = 0;
  int               vec = 0;

  always #5 clk = ~clk;

  always_comb begin
    b_rd_addr = '0;
    for (int k = 0; k < NR; k++)
      b_rd_addr[k*AB +: AB] = a_rd_addr[k*AA +: AB];
  end

  register_file_mp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AA), .NUM_READ(NR),
    .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .wr0_en(wr0_en), .wr0_no_op(wr0_no_op),
    .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data)
  );

  register_file_mp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AB), .NUM_READ(NR),
    .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .wr0_en(wr0_en), .wr0_no_op(wr0_no_op),
    .wr0_addr(wr0_addr[AB-1:0]), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr[AB-1:0]), .wr1_data(wr1_data)
  );

  task automatic chk(input string nm, input int id, input int k,
                     input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s vec%0d port%0d got %h want %h",
               nm, id, k, got, want);
    end
  endtask

  task automatic wa0(input logic [AA-1:0] a, input logic [DW-1:0] d);
    wr0_en = 1'b1; wr0_addr = a; wr0_data = d;
  endtask

  task automatic wa1(input logic [AA-1:0] a, input logic [DW-1:0] d);
    wr1_en = 1'b1; wr1_addr = a; wr1_data = d;
  endtask

  task automatic rd(input int k, input logic [AA-1:0] a);
    rd_en[k] = 1'b1;
    a_rd_addr[k*AA +: AA] = a;
  endtask

  task automatic expa(input int k, input logic [DW-1:0] v);
    exp_a[k*DW +: DW] = v;
    msk_a[k] = 1'b1;
  endtask

  // Push this cycle's expectations, update the B model, advance one clock
  task automatic step();
    rec_t r;
    logic [AB-1:0] ba;
    r.id = 16'(vec);
    r.ea = exp_a;
    r.ma = msk_a;
    r.eb = '0;
    r.mb = rd_en;
    for (int k = 0; k < NR; k++) begin
      ba = a_rd_addr[k*AA +: AB];
      r.eb[k*DW +: DW] = (ba == '0) ? '0 : mdl[ba];
    end
    if (wr0_en && !wr0_no_op && wr0_addr[AB-1:0] != '0)
      mdl[wr0_addr[AB-1:0]] = wr0_data;
    if (wr1_en && wr1_addr[AB-1:0] != '0)
      mdl[wr1_addr[AB-1:0]] = wr1_data;
    sb.push_back(r);
    vec++;
    @(negedge clk);
    wr0_en = 1'b0; wr0_no_op = 1'b0; wr1_en = 1'b0;
    rd_en = '0; exp_a = '0; msk_a = '0;
  endtask

  // Monitor: one record per clock, compared just after the edge
  initial begin
    rec_t r;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        r = sb.pop_front();
        for (int k = 0; k < NR; k++) begin
          if (r.ma[k])
            chk("rd_a", int'(r.id), k, a_rd_data[k*DW +: DW], r.ea[k*DW +: DW]);
          if (r.mb[k])
            chk("rd_b", int'(r.id), k, b_rd_data[k*DW +: DW], r.eb[k*DW +: DW]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    rd_en = '0; a_rd_addr = '0;
    wr0_en = 1'b0; wr0_no_op = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    exp_a = '0; msk_a = '0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NR; k++) begin
      chk("reset_a", -1, k, a_rd_data[k*DW +: DW], '0);
      chk("reset_b", -1, k, b_rd_data[k*DW +: DW], '0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // mid-operation reset
    wa0(5, 32'hDEADBEEF); step();
    rd(0, 5); expa(0, 32'hDEADBEEF); step();
    wa1(6, 32'h0000600D); rd(1, 5); expa(1, 32'hDEADBEEF); step();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NR; k++) begin
      chk("async_rst_a", vec, k, a_rd_data[k*DW +: DW], '0);
      chk("async_rst_b", vec, k, b_rd_data[k*DW +: DW], '0);
    end
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    #1 rst_n = 1'b1;
    rd(0, 5); rd(1, 6); expa(0, '0); expa(1, '0); step();

    // zero register
    wa0(0, 32'h1234); rd(0, 0); expa(0, '0); step();
    rd(0, 0); rd(3, 0); expa(0, '0); expa(3, '0); step();
    wa1(0, 32'h99); rd(2, 0); expa(2, '0); step();

    // bypass (A) versus old value (B)
    wa0(7, 32'hA5A5A5A5); rd(1, 7); expa(1, 32'hA5A5A5A5); step();
    for (int k = 0; k < NR; k++) begin
      rd(k, 7); expa(k, 32'hA5A5A5A5);
    end
    step();

    // write collision and dual write
    wa0(3, 32'h11); wa1(3, 32'h22); rd(0, 3); expa(0, 32'h22); step();
    rd(2, 3); expa(2, 32'h22); step();
    wa0(3, 32'h33); wa1(4, 32'h44);
    rd(0, 3); rd(1, 4); expa(0, 32'h33); expa(1, 32'h44); step();
    rd(0, 3); rd(1, 4); expa(0, 32'h33); expa(1, 32'h44); step();

    // hold and no-op
    rd(0, 9); expa(0, '0); step();
    wa0(9, 32'h55); expa(0, '0); step();
    expa(0, '0); step();
    expa(0, '0); step();
    rd(0, 9); expa(0, 32'h55); step();
    wa0(9, 32'h77); wr0_no_op = 1'b1; rd(0, 9); expa(0, 32'h55); step();
    rd(0, 9); expa(0, 32'h55); expa(1, 32'h44); step();

    // sweep on B: fill then random reads with occasional late writes
    for (int i = 0; i < 8; i++) begin
      wa0(AA'(i), 32'(i) * 32'h01010101);
      for (int k = 0; k < NR; k++) rd(k, AA'($urandom_range(0, 7)));
      step();
    end
    for (int c = 0; c < 24; c++) begin
      if ($urandom_range(0, 2) == 0) wa1(AA'($urandom_range(0, 7)), $urandom);
      for (int k = 0; k < NR; k++)
        if ($urandom_range(0, 3) != 0) rd(k, AA'($urandom_range(0, 7)));
      step();
    end

    repeat (4) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
